// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: timing defaults shared by the VGA generator and sync receiver
package vga_timing_pkg;

    localparam int DEF_HACTIVE  = 256;
    localparam int DEF_HFP      = 192;
    localparam int DEF_HSYN     = 48;
    localparam int DEF_HBP      = 192;
    localparam int DEF_VACTIVE  = 256;
    localparam int DEF_VFP      = 112;
    localparam int DEF_VSYN     = 2;
    localparam int DEF_VBP      = 112;
    localparam int DEF_H_LOCK_N = 4;
    localparam int DEF_V_LOCK_N = 2;

    function automatic int sync_total(input int act, input int fp, input int syn, input int bp);
        return act + fp + syn + bp;
    endfunction

    localparam int DEF_HMAX = sync_total(DEF_HACTIVE, DEF_HFP, DEF_HSYN, DEF_HBP);
    localparam int DEF_VMAX = sync_total(DEF_VACTIVE, DEF_VFP, DEF_VSYN, DEF_VBP);

    typedef enum logic [1:0] {IDLE, H_ACQ, V_ACQ, LOCKED} rx_state_t;

endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: registers a sync input and flags its falling and rising edges
module vga_sync_edge (
    input  logic vga_clk,
    input  logic rst,
    input  logic sync_n,
    output logic fall,
    output logic rise
);

    logic q;

    // previous sample idles high so a line already low at reset release is not an edge
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) q <= 1'b1;
        else     q <= sync_n;
    end

    assign fall = q & ~sync_n;
    assign rise = ~q & sync_n;

endmodule

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: measures VGA sync timing, rebuilds x/y coordinates and declares lock
module vga_sync_receiver
    import vga_timing_pkg::*;
#(
    parameter int HACTIVE  = DEF_HACTIVE,
    parameter int HFP      = DEF_HFP,
    parameter int HSYN     = DEF_HSYN,
    parameter int HBP      = DEF_HBP,
    parameter int VACTIVE  = DEF_VACTIVE,
    parameter int VFP      = DEF_VFP,
    parameter int VSYN     = DEF_VSYN,
    parameter int VBP      = DEF_VBP,
    parameter int H_LOCK_N = DEF_H_LOCK_N,
    parameter int V_LOCK_N = DEF_V_LOCK_N
) (
    input  logic        vga_clk,
    input  logic        rst,
    input  logic        h_sync,
    input  logic        v_sync,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        active,
    output logic        locked,
    output logic        err,
    output logic [10:0] line_len,
    output logic [9:0]  frame_lines
);

    localparam int         HMAX         = sync_total(HACTIVE, HFP, HSYN, HBP);
    localparam int         VMAX         = sync_total(VACTIVE, VFP, VSYN, VBP);
    localparam int         HGW          = $clog2(H_LOCK_N + 1);
    localparam int         VGW          = $clog2(V_LOCK_N + 1);
    localparam logic       X_LOAD_WRAPS = (HACTIVE + HFP + 1 == HMAX);
    localparam logic [9:0] X_LOAD       = X_LOAD_WRAPS ? 10'd0 : 10'(HACTIVE + HFP + 1);
    localparam logic [9:0] Y_LOAD       = 10'(VACTIVE + VFP);

    rx_state_t      state, state_nx;
    logic           hfall, hrise, vfall, vrise_unused;
    logic [10:0]    h_per, h_wid;
    logic [9:0]     line_cnt;
    logic [HGW-1:0] h_good, h_good_nx;
    logic [VGW-1:0] v_good, v_good_nx;
    logic           v_seen, v_seen_nx, err_nx;
    logic           line_good, line_bad, frame_bad, timeout, x_wrap;

    vga_sync_edge u_hs (.vga_clk(vga_clk), .rst(rst), .sync_n(h_sync), .fall(hfall), .rise(hrise));
    vga_sync_edge u_vs (.vga_clk(vga_clk), .rst(rst), .sync_n(v_sync), .fall(vfall), .rise(vrise_unused));

    assign x_wrap    = hfall ? X_LOAD_WRAPS : (x == 10'(HMAX - 1));
    assign line_good = hfall && h_per == 11'(HMAX);
    assign line_bad  = (hfall && !line_good) || (hrise && h_wid != 11'(HSYN));
    assign frame_bad = vfall && line_cnt != 10'(VMAX);
    assign timeout   = state != IDLE && !hfall && h_per == 11'(2 * HMAX);
    assign locked    = state == LOCKED;
    assign active    = locked && x < 10'(HACTIVE) && y < 10'(VACTIVE);

    // lock acquisition: line checks gate frame checks, timeout drops everything
    always_comb begin
        state_nx  = state;
        h_good_nx = h_good;
        v_good_nx = v_good;
        v_seen_nx = v_seen;
        err_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (hfall) begin
                    state_nx  = H_ACQ;
                    h_good_nx = '0;
                end
            end
            H_ACQ: begin
                if (line_bad) begin
                    err_nx    = 1'b1;
                    h_good_nx = '0;
                end else if (line_good) begin
                    h_good_nx = h_good + 1'b1;
                    if (h_good_nx == HGW'(H_LOCK_N)) begin
                        state_nx  = V_ACQ;
                        v_good_nx = '0;
                        v_seen_nx = 1'b0;
                    end
                end
            end
            V_ACQ: begin
                if (line_bad) begin
                    err_nx    = 1'b1;
                    state_nx  = H_ACQ;
                    h_good_nx = '0;
                end else if (vfall && !v_seen) begin
                    v_seen_nx = 1'b1;
                end else if (frame_bad) begin
                    err_nx    = 1'b1;
                    v_good_nx = '0;
                end else if (vfall) begin
                    v_good_nx = v_good + 1'b1;
                    if (v_good_nx == VGW'(V_LOCK_N)) state_nx = LOCKED;
                end
            end
            LOCKED: begin
                if (line_bad) begin
                    err_nx    = 1'b1;
                    state_nx  = H_ACQ;
                    h_good_nx = '0;
                end else if (frame_bad) begin
                    err_nx    = 1'b1;
                    state_nx  = V_ACQ;
                    v_good_nx = '0;
                    v_seen_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (timeout) begin
            err_nx    = 1'b1;
            state_nx  = IDLE;
            h_good_nx = '0;
            v_good_nx = '0;
            v_seen_nx = 1'b0;
        end
    end

    // state, qualification counters and the registered error pulse
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            h_good <= '0;
            v_good <= '0;
            v_seen <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nx;
            h_good <= h_good_nx;
            v_good <= v_good_nx;
            v_seen <= v_seen_nx;
            err    <= err_nx;
        end
    end

    // coordinate reconstruction plus period, pulse-width and line-count measurement
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            x           <= '0;
            y           <= '0;
            h_per       <= '0;
            h_wid       <= '0;
            line_cnt    <= '0;
            line_len    <= '0;
            frame_lines <= '0;
        end else if (timeout) begin
            x        <= '0;
            y        <= '0;
            h_per    <= '0;
            h_wid    <= '0;
            line_cnt <= '0;
        end else begin
            x        <= hfall ? X_LOAD : (state == IDLE || x_wrap) ? '0 : x + 10'd1;
            y        <= (state == IDLE) ? '0 : vfall ? Y_LOAD : !x_wrap ? y : (y == 10'(VMAX - 1)) ? '0 : y + 10'd1;
            h_per    <= hfall ? 11'd1 : (&h_per) ? h_per : h_per + 11'd1;
            h_wid    <= hfall ? 11'd1 : (h_sync || &h_wid) ? h_wid : h_wid + 11'd1;
            line_cnt <= vfall ? {9'd0, hfall} : (&line_cnt) ? line_cnt : line_cnt + {9'd0, hfall};
            if (hfall) line_len <= h_per;
            if (vfall) frame_lines <= line_cnt;
        end
    end

endmodule

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
- Sink-side counterpart of the VGA timing generator: consumes active-low h_sync/v_sync.
- Measures line period, pulse width and lines per frame, and checks them against nominal timing.
- Reconstructs the generator's x/y pixel coordinates and declares lock.
- Feeds test/monitor logic and any downstream pixel consumer that needs coordinates without direct access to the generator's counters.

Parameters:
- HACTIVE, 256, active pixels per line
- HFP, 192, horizontal front porch
- HSYN, 48, h_sync pulse width in clocks
- HBP, 192, horizontal back porch
- VACTIVE, 256, active lines
- VFP, 112, vertical front porch
- VSYN, 2, v_sync pulse width in lines
- VBP, 112, vertical back porch
- H_LOCK_N, 4, consecutive correct line periods required for horizontal lock
- V_LOCK_N, 2, consecutive correct frames required for vertical lock
- Derived (localparam): HMAX = HACTIVE+HFP+HSYN+HBP (688); VMAX = VACTIVE+VFP+VSYN+VBP (482)

Ports:
- vga_clk  in  1  pixel clock, same domain as the generator
- rst  in  1  asynchronous, active-high reset
- h_sync  in  1  active-low horizontal sync
- v_sync  in  1  active-low vertical sync
- x  out  10  reconstructed pixel column
- y  out  10  reconstructed line
- active  out  1  (x<HACTIVE)&(y<VACTIVE); forced 0 unless locked
- locked  out  1  horizontal and vertical lock achieved
- err  out  1  one-cycle pulse on any timing violation
- line_len  out  11  last measured h_sync fall-to-fall period
- frame_lines  out  10  last measured lines between v_sync falls

Behaviour:
- Clock and reset: one clock, vga_clk. Reset is asynchronous and active-high (rst).
- Reset values: state=IDLE; x, y, active, locked, err, line_len, frame_lines = 0; all internal counters = 0.
- Edge detection: hs_q/vs_q register the previous sample. hfall = hs_q&~h_sync, hrise = ~hs_q&h_sync (likewise for v_sync). hs_q/vs_q reset to 1, so a low input at reset release is not an edge.
- Horizontal alignment: on the cycle hfall is seen, the generator x is HACTIVE+HFP. Load x <= HACTIVE+HFP+1 (wrap to 0 if equal to HMAX). From the next cycle, x equals the generator x with zero offset.
- Vertical alignment: on vfall, load y <= VACTIVE+VFP; x is still handled by the horizontal rules.
- Free-running coordinates: outside load cycles, x increments; at HMAX-1, x goes to 0 and y increments; y wraps VMAX-1 to 0. A y load has priority over the wrap increment.
- Period counter (11 bits) h_per:
  - Reset to 1 on hfall, otherwise increments, saturating at 2047.
  - On hfall: line_len <= h_per. Good line if h_per==HMAX.
- Pulse-width counter: counts h_sync low cycles; checked at hrise; must equal HSYN.
- Line counter: counts hfalls between vfalls. On vfall: frame_lines <= count. Good frame if count==VMAX.
- FSM:
  - IDLE: x, y held 0. First hfall goes to H_ACQ; h_good=0.
  - H_ACQ: each good line increments h_good; a bad period or width clears h_good and pulses err. When h_good reaches H_LOCK_N, go to V_ACQ with v_good=0.
  - V_ACQ: the first vfall only starts the line count. Each subsequent good frame increments v_good. A bad frame clears v_good and pulses err. When v_good reaches V_LOCK_N, go to LOCKED.
  - LOCKED: locked=1. A bad line period or width pulses err and goes to H_ACQ. A bad frame pulses err and goes to V_ACQ.
  - Any state except IDLE: h_per reaching 2*HMAX without an hfall means timeout. Pulse err, go to IDLE, zero x, y and counters.
- Simultaneous events:
  - hfall and vfall in one cycle: apply the x load and y load both.
  - A line error and a frame error in one cycle: H_ACQ wins; err is one pulse.
- err is registered: it is asserted the cycle after detection, for one cycle.
- Reset mid-operation: asynchronous return to reset values; lock must be reacquired from IDLE.

Decomposition:
- Package vga_timing_pkg holds:
  - Default timing constants, shared with the generator.
  - HMAX/VMAX derivation.
  - The rx_state_t enum {IDLE, H_ACQ, V_ACQ, LOCKED}.
- One sub-module, vga_sync_edge: a sample register plus fall/rise outputs with reset-to-1. Instantiate it twice, for h_sync and v_sync.

Test Plan:
- Nominal lock: drive the generator directly from reset release. Required:
  - locked rises during the frame after the third vfall.
  - x and y match the generator every cycle after lock.
  - active matches blank_b.
  - line_len=688, frame_lines=482, err never pulses.
- Horizontal-only check: after 5 hfalls with 688-cycle period, state=V_ACQ and locked=0.
- Line glitch while locked: stretch one line to 689 clocks. Required: err pulses once, locked drops, state=H_ACQ, line_len=689; locked returns after relock.
- Pulse width error: one h_sync pulse 47 clocks wide. Required: err pulses at the hrise, h_good clears.
- Sync loss: hold h_sync high for 1400 clocks while locked. Required: err pulses at h_per=1376, state=IDLE, x=y=0, locked=0.
- Async reset mid-frame: assert rst for 3 clocks at y=100. Required: all outputs 0 immediately (without waiting for a clock edge); full reacquisition follows.
